rd_ptr_level_handler: RTL

Parametrised read-side pointer controller for the async FIFO. It integrates the gray write-pointer synchroniser and computes empty, almost-empty, fill level and underflow in the read domain. It drives the binary read address to FIFO memory and the gray read pointer back to the write domain. Sits between the read-domain consumer, FIFO memory and the write-side pointer handler.

---
 rtl/rd_ptr_level_handler.sv | 83 ++++++++
 1 files changed

// File: rtl/rd_ptr_level_handler.sv
// Read-side pointer controller for the async FIFO: synchronises the gray
// write pointer and produces the read address, gray read pointer, empty,
// almost-empty, fill level and underflow flags in the read clock domain.
module rd_ptr_level_handler #(
  parameter int unsigned PTR_WIDTH   = 3,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  input  logic                 i_en,
  input  logic [PTR_WIDTH:0]   i_g_wr_ptr,
  input  logic [PTR_WIDTH:0]   i_ae_thresh,
  output logic                 o_rd_accept,
  output logic [PTR_WIDTH:0]   o_b_rd_ptr,
  output logic [PTR_WIDTH:0]   o_g_rd_ptr,
  output logic                 o_empty,
  output logic                 o_almost_empty,
  output logic [PTR_WIDTH:0]   o_rd_level,
  output logic                 o_underflow
);

  localparam int unsigned PW = PTR_WIDTH + 1;

  logic [PW-1:0] r_sync [SYNC_STAGES];
  logic [PW-1:0] w_wr_g_s;
  logic [PW-1:0] w_wr_b_s;
  logic [PW-1:0] w_nxt_b;
  logic [PW-1:0] w_nxt_g;
  logic [PW-1:0] w_nxt_level;
  logic          w_acc;

  // Multi-flop synchroniser for the write-domain gray pointer
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= '0;
      end
    end else begin
      r_sync[0] <= i_g_wr_ptr;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign w_wr_g_s = r_sync[SYNC_STAGES-1];

  // Gray-to-binary of the synchronised write pointer (XOR of all bits at or above)
  always_comb begin
    w_wr_b_s = '0;
    for (int unsigned i = 0; i < PW; i++) begin
      w_wr_b_s[i] = ^(w_wr_g_s >> i);
    end
  end

  // Accept only against the registered (pessimistic) empty flag
  assign w_acc       = i_en & ~o_empty;
  assign o_rd_accept = w_acc;

  assign w_nxt_b     = o_b_rd_ptr + PW'(w_acc);
  assign w_nxt_g     = w_nxt_b ^ (w_nxt_b >> 1);
  assign w_nxt_level = w_wr_b_s - w_nxt_b;

  // Pointer and status registers; status reflects the read taken at this edge
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      o_b_rd_ptr     <= '0;
      o_g_rd_ptr     <= '0;
      o_empty        <= 1'b1;
      o_almost_empty <= 1'b1;
      o_rd_level     <= '0;
      o_underflow    <= 1'b0;
    end else begin
      o_b_rd_ptr     <= w_nxt_b;
      o_g_rd_ptr     <= w_nxt_g;
      o_empty        <= (w_nxt_g == w_wr_g_s);
      o_almost_empty <= (w_nxt_level <= i_ae_thresh);
      o_rd_level     <= w_nxt_level;
      o_underflow    <= i_en & o_empty;
    end
  end

endmodule
